// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the fft_256 post-processing blocks.
package fft_pkg;

    localparam int DATA_WIDTH = 18;
    localparam int FFT_SIZE   = 256;
    localparam int BIN_W      = $clog2(FFT_SIZE);
    localparam int MAG_W      = 2 * DATA_WIDTH;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [BIN_W-1:0] bin_t;

    // IDLE: bin counter at 0 and pipeline empty; FRAME: otherwise.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } fft_state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: two-stage re^2 + im^2 pipeline with a shared advance enable and a
// tag carried alongside each sample. Stage-1 results are also exposed for look-ahead.
module fft_mag_sq #(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int TAG_W      = fft_pkg::BIN_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] re_i,
    input  logic signed [DATA_WIDTH-1:0] im_i,
    input  logic [TAG_W-1:0]             tag_i,
    output logic                         s1_valid_o,
    output logic [2*DATA_WIDTH-1:0]      s1_mag_o,
    output logic [TAG_W-1:0]             s1_tag_o,
    output logic                         valid_o,
    output logic [2*DATA_WIDTH-1:0]      mag_o,
    output logic [TAG_W-1:0]             tag_o
);
    import fft_pkg::*;

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int SQ_W = 2 * DATA_WIDTH - 1;

    logic [PW-1:0]   re_ext;
    logic [PW-1:0]   im_ext;
    logic [SQ_W-1:0] re_sq_d;
    logic [SQ_W-1:0] im_sq_d;
    logic [SQ_W-1:0] re_sq_q;
    logic [SQ_W-1:0] im_sq_q;

    // A square never exceeds 2^(2*DATA_WIDTH-2), so the low SQ_W bits of the
    // modular product of the sign-extended operands are exact.
    assign re_ext  = {{DATA_WIDTH{re_i[DATA_WIDTH-1]}}, re_i};
    assign im_ext  = {{DATA_WIDTH{im_i[DATA_WIDTH-1]}}, im_i};
    assign re_sq_d = SQ_W'(re_ext * re_ext);
    assign im_sq_d = SQ_W'(im_ext * im_ext);

    assign s1_mag_o = {1'b0, re_sq_q} + {1'b0, im_sq_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_o <= 1'b0;
            re_sq_q    <= '0;
            im_sq_q    <= '0;
            s1_tag_o   <= '0;
            valid_o    <= 1'b0;
            mag_o      <= '0;
            tag_o      <= '0;
        end else if (en_i) begin
            s1_valid_o <= valid_i;
            if (valid_i) begin
                re_sq_q  <= re_sq_d;
                im_sq_q  <= im_sq_d;
                s1_tag_o <= tag_i;
            end
            valid_o <= s1_valid_o;
            if (s1_valid_o) begin
                mag_o <= s1_mag_o;
                tag_o <= s1_tag_o;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: per-bin magnitude-squared stream plus per-frame peak bin search.
// Build option: define PEAK_SKIP_DC_EN to exclude bin 0 from the peak search.
module fft_peak_detector #(
    parameter int DATA_WIDTH   = fft_pkg::DATA_WIDTH,
    parameter int FFT_SIZE     = fft_pkg::FFT_SIZE,
    parameter int BIN_W        = $clog2(FFT_SIZE),
    parameter int MAG_W        = 2 * DATA_WIDTH,
    parameter int SEARCH_LIMIT = FFT_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] data_real_i,
    input  logic signed [DATA_WIDTH-1:0] data_imag_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [MAG_W-1:0]             mag_o,
    output logic [BIN_W-1:0]             mag_bin_o,
    output logic                         mag_valid_o,
    input  logic                         mag_ready_i,
    output logic [BIN_W-1:0]             peak_bin_o,
    output logic [MAG_W-1:0]             peak_mag_o,
    output logic                         peak_valid_o,
    output logic                         frame_active_o,
    output fft_pkg::fft_state_e          dbg_state_o
);
    import fft_pkg::*;

    // Handshakes: a word moves when valid and ready are both high at a clock
    // edge; valid and its data stay stable until taken, ready never waits on valid.
    fft_state_e       state_q;
    fft_state_e       state_d;
    logic             adv;
    logic             xfer;
    logic             enter;
    logic             eligible;
    logic             last_bin;
    logic             s1_valid;
    logic             s1_valid_d;
    logic             s2_valid_d;
    logic [BIN_W-1:0] s1_bin;
    logic [MAG_W-1:0] s1_mag;
    logic [BIN_W-1:0] bin_cnt_q;
    logic [BIN_W-1:0] bin_cnt_d;
    logic [MAG_W-1:0] run_mag_q;
    logic [MAG_W-1:0] run_mag_d;
    logic [BIN_W-1:0] run_bin_q;
    logic [BIN_W-1:0] run_bin_d;

    assign adv     = !mag_valid_o || mag_ready_i;
    assign ready_o = adv && !rst_i;
    assign xfer    = valid_i && ready_o;
    assign enter   = adv && s1_valid;

    fft_mag_sq #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAG_W     (BIN_W)
    ) u_mag_sq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (adv),
        .valid_i   (xfer),
        .re_i      (data_real_i),
        .im_i      (data_imag_i),
        .tag_i     (bin_cnt_q),
        .s1_valid_o(s1_valid),
        .s1_mag_o  (s1_mag),
        .s1_tag_o  (s1_bin),
        .valid_o   (mag_valid_o),
        .mag_o     (mag_o),
        .tag_o     (mag_bin_o)
    );

    assign bin_cnt_d = xfer ? bin_cnt_q + 1'b1 : bin_cnt_q;
    assign last_bin  = (s1_bin == BIN_W'(FFT_SIZE - 1));

    // Running maximum as it will stand once the stage-1 bin moves to stage 2.
    always_comb begin
        eligible  = (32'(s1_bin) < SEARCH_LIMIT);
`ifdef PEAK_SKIP_DC_EN
        if (s1_bin == '0) begin
            eligible = 1'b0;
        end
`endif
        run_mag_d = run_mag_q;
        run_bin_d = run_bin_q;
        if (s1_bin == '0) begin
            run_mag_d = eligible ? s1_mag : '0;
            run_bin_d = '0;
        end else if (eligible && (s1_mag > run_mag_q)) begin
            run_mag_d = s1_mag;
            run_bin_d = s1_bin;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_cnt_q    <= '0;
            run_mag_q    <= '0;
            run_bin_q    <= '0;
            peak_bin_o   <= '0;
            peak_mag_o   <= '0;
            peak_valid_o <= 1'b0;
        end else begin
            bin_cnt_q    <= bin_cnt_d;
            peak_valid_o <= 1'b0;
            if (enter) begin
                run_mag_q <= run_mag_d;
                run_bin_q <= run_bin_d;
                if (last_bin) begin
                    peak_bin_o   <= run_bin_d;
                    peak_mag_o   <= run_mag_d;
                    peak_valid_o <= 1'b1;
                end
            end
        end
    end

    assign s1_valid_d = adv ? xfer : s1_valid;
    assign s2_valid_d = adv ? s1_valid : mag_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if ((bin_cnt_d != '0) || s1_valid_d || s2_valid_d) begin
            state_d = ST_FRAME;
        end
    end

    assign frame_active_o = (state_q == ST_FRAME);
    assign dbg_state_o    = state_q;

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
Sits directly downstream of fft_256 and consumes its 256-bin complex output stream over a valid/ready handshake. For each bin it computes the unsigned magnitude-squared (re² + im²) in a 2-stage pipeline and forwards it as a per-bin stream. It also tracks the maximum bin across each frame and reports the peak bin index and magnitude once per frame. The peak result feeds the downstream frequency-estimation and control logic.

Parameters:
DATA_WIDTH, 18, signed width of the real and imaginary input parts.
FFT_SIZE, 256, number of bins per frame; must be a power of two.
BIN_W, $clog2(FFT_SIZE), width of the bin index.
MAG_W, 2*DATA_WIDTH, width of the unsigned magnitude-squared.
SEARCH_LIMIT, FFT_SIZE, only bins with index < SEARCH_LIMIT take part in the peak search. Set to FFT_SIZE/2 for real-input signals.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
data_real_i  in  DATA_WIDTH  signed real part of the bin (from fft_256 data_real_o)
data_imag_i  in  DATA_WIDTH  signed imaginary part of the bin
valid_i  in  1  input bin valid
ready_o  out  1  block can accept a bin
mag_o  out  MAG_W  unsigned magnitude-squared of the bin
mag_bin_o  out  BIN_W  bin index of mag_o
mag_valid_o  out  1  mag_o valid
mag_ready_i  in  1  downstream accepts mag_o
peak_bin_o  out  BIN_W  bin index of the last frame's peak
peak_mag_o  out  MAG_W  magnitude-squared of the last frame's peak
peak_valid_o  out  1  one-cycle pulse when the peak result updates
frame_active_o  out  1  high from the first accepted bin of a frame until its last bin leaves the pipeline

Behaviour:
- Reset (asynchronous, rst_i=1): all outputs are 0, the bin counter is 0, the running maximum is 0, and the pipeline valid bits are cleared. A reset in the middle of a frame discards the partial frame; no peak pulse is issued for it.
- Stall rule: adv = !mag_valid_o || mag_ready_i; ready_o = adv. The whole pipeline moves only when adv=1, and register contents are held while stalled.
- A transfer occurs when valid_i && ready_o.
- Stage 1 (on transfer): register re² and im² as unsigned 2*DATA_WIDTH-1-bit values; the input -2^17 squared gives 2^34 exactly. Also register the bin index and the stage-1 valid bit.
- Stage 2: mag = re² + im², zero-extended to MAG_W (maximum 2^35, no overflow). Drives mag_o, mag_bin_o and mag_valid_o. Latency is 2 cycles from transfer to mag_valid_o when not stalled.
- Bin counter: incremented on each input transfer and wraps from FFT_SIZE-1 to 0. A frame is FFT_SIZE consecutive transfers; idle cycles inside a frame are allowed.
- Peak search: evaluated when a bin enters stage 2.
  - Bin 0 of a frame loads the running maximum unconditionally, provided it is eligible.
  - A later eligible bin replaces the maximum only if mag > max (strict), so ties keep the lowest index.
  - Eligible means bin < SEARCH_LIMIT.
- End of frame: when bin FFT_SIZE-1 enters stage 2, peak_bin_o and peak_mag_o load the final maximum (including that bin, if eligible), and peak_valid_o pulses high for exactly 1 cycle. Both peak outputs hold until the next frame end.
- Back-to-back frames: a bin 0 arriving in the same cycle as the end-of-frame update starts a fresh maximum. There is no bubble between frames.
- States: IDLE (counter=0, pipeline empty) and FRAME (counter≠0 or pipeline holding data). frame_active_o = (state==FRAME).

Optional Feature:
PEAK_SKIP_DC_EN
- Defined: bin 0 is never eligible for the peak search, and the running maximum is initialised to 0 at the start of each frame. It is still emitted on mag_o.
- Undefined: bin 0 is eligible, subject to SEARCH_LIMIT.

Decomposition:
- Package fft_pkg: DATA_WIDTH, FFT_SIZE, BIN_W, MAG_W constants; typedef of a complex sample {re, im}; typedef mag_t of MAG_W bits; typedef bin_t of BIN_W bits.
- One sub-module, fft_mag_sq: the 2-stage squarer/adder pipeline with a shared enable. Peak tracking and the bin counter live in the top level.

Test Plan:
1. Single tone: real=32767, im=0 at bin 16; all other bins 0. Expect peak_bin_o=16, peak_mag_o=1073676289, and one peak_valid_o pulse after the 256th bin leaves stage 2.
2. Extreme values: bin 5 = (-131072, -131072), all others 1. Expect mag_o for bin 5 = 34359738368 with no overflow, and peak_bin_o=5.
3. Tie and search limit:
   - With SEARCH_LIMIT=128: bins 20 and 200 = (1000, 0), bin 40 = (0, 1000). Expect peak_bin_o=20 (lowest index wins; bin 200 excluded).
   - Second frame: same stimulus plus bin 200 = (2000, 0). Expect peak_bin_o still 20.
4. Backpressure: hold mag_ready_i low for 10 cycles mid-frame. Expect ready_o=0 during the stall, mag_o/mag_bin_o stable, and no lost or duplicated bins (256 mag outputs with indices 0..255 in order).
5. DC frame with all bins = (65535, 0):
   - Macro undefined: peak_bin_o=0, peak_mag_o=4294836225.
   - PEAK_SKIP_DC_EN defined: peak_bin_o=1, since bin 1 is the first eligible bin and ties keep the lowest index.
6. Reset mid-frame: assert rst_i after 100 bins. Expect all outputs 0 immediately, no peak pulse, and the next full frame reporting a correct peak starting from bin 0.
